// File: rtl/pwm_fade_pkg.sv
// ---------------------------------------------------------------------------
// pwm_fade_pkg
// Shared constants for the PWM fade controller: FSM state encodings and the
// ramp step size applied on every step event.
// Optional feature macro used by the controller: PWM_FADE_BREATHE_EN.
// ---------------------------------------------------------------------------
package pwm_fade_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
    localparam logic [1:0] ST_HOLD      = 2'd3;

    // Duty change applied per step event
    localparam int unsigned FADE_STEP = 1;

endpackage

// File: rtl/fade_tick_gen.sv
// ---------------------------------------------------------------------------
// fade_tick_gen
// Step prescaler for the fade ramp. Counts 0..div and raises tick while the
// count equals div, so div = 0 yields a tick every cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clear : restart the count at 0 on the next cycle
//   div   : cycles per tick minus one
//   tick  : step event (combinational from the registered count)
// ---------------------------------------------------------------------------
module fade_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign tick = (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        // Wrap on >= so a div lowered below the current count recovers
        // immediately instead of running the counter all the way round.
        if (clear || (cnt_q >= div)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_fade_ctrl
// Ramps the duty value fed to a downstream PWM stage toward a requested
// target, one unit per step event, then holds it.
// Optional feature: define PWM_FADE_BREATHE_EN to enable auto-breathing
// (ramp back and forth between 0 and max_value while breathe_en is high).
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   tgt_duty, tgt_max   : requested final duty and PWM period maximum
//   tgt_valid/tgt_ready : target handshake (ready only in IDLE/HOLD)
//   step_div            : cycles per ramp step minus one
//   breathe_en          : auto-breathing request (optional feature only)
//   duty, max_value     : registered values to the PWM stage
//   busy                : high while ramping
//   done_pulse          : one-cycle pulse when duty reaches the target
// ---------------------------------------------------------------------------
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] tgt_duty,
    input  logic [BIT_WIDTH-1:0] tgt_max,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [DIV_WIDTH-1:0] step_div,
    input  logic                 breathe_en,
    output logic [BIT_WIDTH-1:0] duty,
    output logic [BIT_WIDTH-1:0] max_value,
    output logic                 busy,
    output logic                 done_pulse
);

    localparam logic [BIT_WIDTH-1:0] STEP = BIT_WIDTH'(FADE_STEP);

    logic [1:0]           state_q,  state_d;
    logic [BIT_WIDTH-1:0] duty_q,   duty_d;
    logic [BIT_WIDTH-1:0] max_q,    max_d;
    logic [BIT_WIDTH-1:0] target_q, target_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic                 accept;
    logic                 tick;
    logic                 tick_clear;
    logic [BIT_WIDTH-1:0] tgt_clamped;
    logic [BIT_WIDTH-1:0] duty_clamped;
    logic [BIT_WIDTH-1:0] duty_inc;
    logic [BIT_WIDTH-1:0] duty_dec;

`ifdef PWM_FADE_BREATHE_EN
    logic [BIT_WIDTH-1:0] breathe_tgt;
    assign breathe_tgt = (duty_q == max_q) ? '0 : max_q;
`else
    logic unused_breathe;
    assign unused_breathe = breathe_en;
`endif

    assign tgt_ready    = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign accept       = tgt_valid && tgt_ready;
    assign tgt_clamped  = (tgt_duty > tgt_max) ? tgt_max : tgt_duty;
    // Duty is pulled down to the new maximum in the acceptance cycle, so the
    // ramp direction is decided against the clamped value.
    assign duty_clamped = (duty_q > tgt_max) ? tgt_max : duty_q;
    assign duty_inc     = duty_q + STEP;
    assign duty_dec     = duty_q - STEP;

    fade_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .div   (step_div),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        max_d      = max_q;
        target_d   = target_q;
        done_d     = 1'b0;
        tick_clear = 1'b0;

        if (accept) begin
            max_d      = tgt_max;
            duty_d     = duty_clamped;
            target_d   = tgt_clamped;
            tick_clear = 1'b1;
            if (tgt_clamped > duty_clamped) begin
                state_d = ST_RAMP_UP;
            end else if (tgt_clamped < duty_clamped) begin
                state_d = ST_RAMP_DOWN;
            end else begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RAMP_UP: begin
                    // The >= guard keeps the ramp from ever stepping past its
                    // target, which is itself never above max_value.
                    if (duty_q >= target_q) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        duty_d = duty_inc;
                        if (duty_inc == target_q) begin
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (duty_q <= target_q) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        duty_d = duty_dec;
                        if (duty_dec == target_q) begin
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end
                    end
                end
`ifdef PWM_FADE_BREATHE_EN
                ST_HOLD: begin
                    // Bounce between the endpoints; a degenerate max of 0
                    // with duty 0 simply stays put.
                    if (breathe_en && (breathe_tgt != duty_q)) begin
                        target_d   = breathe_tgt;
                        tick_clear = 1'b1;
                        state_d    = (breathe_tgt > duty_q) ? ST_RAMP_UP : ST_RAMP_DOWN;
                    end
                end
`endif
                default: ;
            endcase
        end

        busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            max_q    <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            max_q    <= max_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign duty       = duty_q;
    assign max_value  = max_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_fade_ctrl
// Directed, self-checking bench for pwm_fade_ctrl (BIT_WIDTH = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the state registered at that edge.
// ---------------------------------------------------------------------------
module tb_pwm_fade_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tgt_duty;
    logic [7:0]  tgt_max;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [15:0] step_div;
    logic        breathe_en;
    logic [7:0]  duty;
    logic [7:0]  max_value;
    logic        busy;
    logic        done_pulse;

    int n_cmp = 0;
    int n_err = 0;

    pwm_fade_ctrl #(
        .BIT_WIDTH (8),
        .DIV_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_duty   (tgt_duty),
        .tgt_max    (tgt_max),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .step_div   (step_div),
        .breathe_en (breathe_en),
        .duty       (duty),
        .max_value  (max_value),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a target for exactly one edge; returns after that edge.
    task automatic send(input logic [7:0] d, input logic [7:0] m, input logic [15:0] dv);
        tgt_duty  = d;
        tgt_max   = m;
        step_div  = dv;
        tgt_valid = 1'b1;
        $display("[%0t] request duty=%0d max=%0d div=%0d ready=%0b", $time, d, m, dv, tgt_ready);
        step();
        tgt_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (duty !== 8'd0) begin n_err++; $display("FAIL reset_duty got=%0d exp=0", duty); end
        n_cmp++; if (max_value !== 8'd0) begin n_err++; $display("FAIL reset_max got=%0d exp=0", max_value); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", done_pulse); end
        n_cmp++; if (tgt_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", tgt_ready); end
        $display("[%0t] reset done duty=%0d max=%0d", $time, duty, max_value);
    endtask

    // 0 -> 10, one step per cycle
    task automatic test_ramp_up();
        int busy_cnt = 0;
        int done_cnt = 0;
        send(8'd10, 8'd255, 16'd0);
        n_cmp++; if (duty !== 8'd0) begin n_err++; $display("FAIL up_start_duty got=%0d exp=0", duty); end
        n_cmp++; if (max_value !== 8'd255) begin n_err++; $display("FAIL up_max got=%0d exp=255", max_value); end
        n_cmp++; if (tgt_ready !== 1'b0) begin n_err++; $display("FAIL up_ready_low got=%0b exp=0", tgt_ready); end
        if (busy === 1'b1) busy_cnt++;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++; if (duty !== 8'(i)) begin n_err++; $display("FAIL up_duty step=%0d got=%0d exp=%0d", i, duty, i); end
            n_cmp++; if (done_pulse !== (i == 10)) begin n_err++; $display("FAIL up_done step=%0d got=%0b exp=%0b", i, done_pulse, (i == 10)); end
            if (busy === 1'b1) busy_cnt++;
            if (done_pulse === 1'b1) done_cnt++;
        end
        step();
        if (done_pulse === 1'b1) done_cnt++;
        n_cmp++; if (busy_cnt != 10) begin n_err++; $display("FAIL up_busy_cycles got=%0d exp=10", busy_cnt); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL up_done_count got=%0d exp=1", done_cnt); end
        n_cmp++; if (tgt_ready !== 1'b1) begin n_err++; $display("FAIL up_ready_back got=%0b exp=1", tgt_ready); end
        $display("[%0t] ramp up finished duty=%0d", $time, duty);
    endtask

    // 10 -> 4, one step every 4 cycles
    task automatic test_ramp_down();
        int done_cnt = 0;
        send(8'd4, 8'd255, 16'd3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL down_busy got=%0b exp=1", busy); end
        for (int k = 1; k <= 24; k++) begin
            step();
            n_cmp++; if (duty !== 8'(10 - k / 4)) begin n_err++; $display("FAIL down_duty cyc=%0d got=%0d exp=%0d", k, duty, 10 - k / 4); end
            if (done_pulse === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL down_done_at_end got=%0b exp=1", done_pulse); end
        step();
        if (done_pulse === 1'b1) done_cnt++;
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL down_done_count got=%0d exp=1", done_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL down_busy_end got=%0b exp=0", busy); end
        $display("[%0t] ramp down finished duty=%0d", $time, duty);
    endtask

    // 4 -> 200, then retarget with max below current duty
    task automatic test_clamp();
        int busy_cnt = 0;
        send(8'd200, 8'd255, 16'd0);
        for (int k = 1; k <= 196; k++) step();
        n_cmp++; if (duty !== 8'd200) begin n_err++; $display("FAIL clamp_pre_duty got=%0d exp=200", duty); end
        step();
        send(8'd250, 8'd100, 16'd0);
        if (busy === 1'b1) busy_cnt++;
        n_cmp++; if (max_value !== 8'd100) begin n_err++; $display("FAIL clamp_max got=%0d exp=100", max_value); end
        n_cmp++; if (duty !== 8'd100) begin n_err++; $display("FAIL clamp_duty got=%0d exp=100", duty); end
        n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL clamp_done got=%0b exp=1", done_pulse); end
        n_cmp++; if (tgt_ready !== 1'b1) begin n_err++; $display("FAIL clamp_ready got=%0b exp=1", tgt_ready); end
        step();
        if (busy === 1'b1) busy_cnt++;
        n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL clamp_done_clear got=%0b exp=0", done_pulse); end
        n_cmp++; if (duty !== 8'd100) begin n_err++; $display("FAIL clamp_hold_duty got=%0d exp=100", duty); end
        n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL clamp_busy_seen got=%0d exp=0", busy_cnt); end
        $display("[%0t] clamp finished duty=%0d max=%0d", $time, duty, max_value);
    endtask

    // 100 -> 50 with a stray request mid-ramp
    task automatic test_ignore();
        int done_cnt = 0;
        send(8'd50, 8'd100, 16'd0);
        for (int k = 1; k <= 50; k++) begin
            if (k == 5) begin
                n_cmp++; if (tgt_ready !== 1'b0) begin n_err++; $display("FAIL ign_ready got=%0b exp=0", tgt_ready); end
                tgt_duty  = 8'd5;
                tgt_max   = 8'd200;
                tgt_valid = 1'b1;
                $display("[%0t] stray request duty=5 during ramp", $time);
            end
            step();
            tgt_valid = 1'b0;
            n_cmp++; if (duty !== 8'(100 - k)) begin n_err++; $display("FAIL ign_duty cyc=%0d got=%0d exp=%0d", k, duty, 100 - k); end
            if (done_pulse === 1'b1) done_cnt++;
        end
        n_cmp++; if (max_value !== 8'd100) begin n_err++; $display("FAIL ign_max got=%0d exp=100", max_value); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
        step();
        n_cmp++; if (duty !== 8'd50) begin n_err++; $display("FAIL ign_hold got=%0d exp=50", duty); end
        $display("[%0t] ignore test finished duty=%0d", $time, duty);
    endtask

    // 50 -> 200 interrupted by reset
    task automatic test_reset_mid();
        int done_cnt = 0;
        send(8'd200, 8'd255, 16'd0);
        for (int k = 1; k <= 10; k++) step();
        n_cmp++; if (duty !== 8'd60) begin n_err++; $display("FAIL rmid_pre_duty got=%0d exp=60", duty); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (duty !== 8'd0) begin n_err++; $display("FAIL rmid_duty got=%0d exp=0", duty); end
        n_cmp++; if (max_value !== 8'd0) begin n_err++; $display("FAIL rmid_max got=%0d exp=0", max_value); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
        n_cmp++; if (tgt_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got=%0b exp=1", tgt_ready); end
        for (int k = 0; k < 8; k++) begin
            if (done_pulse === 1'b1) done_cnt++;
            step();
        end
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rmid_done_count got=%0d exp=0", done_cnt); end
        n_cmp++; if (duty !== 8'd0) begin n_err++; $display("FAIL rmid_stay got=%0d exp=0", duty); end
        $display("[%0t] reset mid-ramp finished duty=%0d", $time, duty);
    endtask

    // 0 -> 3 (div 1), retarget 1 immediately, then same target again
    task automatic test_back_to_back();
        send(8'd3, 8'd255, 16'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++; if (duty !== 8'(k / 2)) begin n_err++; $display("FAIL b2b_up cyc=%0d got=%0d exp=%0d", k, duty, k / 2); end
        end
        n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_up_done got=%0b exp=1", done_pulse); end
        send(8'd1, 8'd255, 16'd1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_down_busy got=%0b exp=1", busy); end
        for (int j = 1; j <= 4; j++) begin
            step();
            n_cmp++; if (duty !== 8'(3 - j / 2)) begin n_err++; $display("FAIL b2b_down cyc=%0d got=%0d exp=%0d", j, duty, 3 - j / 2); end
        end
        n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_down_done got=%0b exp=1", done_pulse); end
        send(8'd1, 8'd255, 16'd1);
        n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_equal_done got=%0b exp=1", done_pulse); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_equal_busy got=%0b exp=0", busy); end
        step();
        $display("[%0t] back-to-back finished duty=%0d", $time, duty);
    endtask

    task automatic test_breathe();
`ifdef PWM_FADE_BREATHE_EN
        logic [7:0] exp_duty [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        breathe_en = 1'b1;
        send(8'd3, 8'd3, 16'd0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            n_cmp++; if (duty !== exp_duty[k]) begin n_err++; $display("FAIL breathe_duty cyc=%0d got=%0d exp=%0d", k, duty, exp_duty[k]); end
            n_cmp++; if (done_pulse !== (k == 3 || k == 7 || k == 11)) begin n_err++; $display("FAIL breathe_done cyc=%0d got=%0b", k, done_pulse); end
        end
        breathe_en = 1'b0;
        $display("[%0t] breathe finished duty=%0d", $time, duty);
`else
        // Feature absent: breathe_en must not disturb a held value.
        breathe_en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_cmp++; if (duty !== 8'd1) begin n_err++; $display("FAIL breathe_off_duty got=%0d exp=1", duty); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL breathe_off_busy got=%0b exp=0", busy); end
        breathe_en = 1'b0;
        $display("[%0t] breathe disabled check duty=%0d", $time, duty);
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        tgt_duty   = '0;
        tgt_max    = '0;
        tgt_valid  = 1'b0;
        step_div   = '0;
        breathe_en = 1'b0;
        #1;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clamp();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_breathe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, width of duty/max values (matches the downstream PWM stage).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the step prescaler.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tgt_duty  input  BIT_WIDTH  requested final duty.
REQ-006 SHALL have port tgt_max  input  BIT_WIDTH  requested PWM period maximum.
REQ-007 SHALL have port tgt_valid  input  1  target request.
REQ-008 SHALL have port tgt_ready  output  1  target acceptance.
REQ-009 SHALL have port step_div  input  DIV_WIDTH  cycles per ramp step, minus one.
REQ-010 SHALL have port breathe_en  input  1  auto-breathing request (used only per REQ-027).
REQ-011 SHALL have port duty  output  BIT_WIDTH  duty to the PWM stage.
REQ-012 SHALL have port max_value  output  BIT_WIDTH  period maximum to the PWM stage.
REQ-013 SHALL have port busy  output  1  high while ramping.
REQ-014 SHALL have port done_pulse  output  1  one-cycle pulse when duty reaches target.

Function
REQ-015 SHALL implement states IDLE, RAMP_UP, RAMP_DOWN, HOLD; registered outputs only.
REQ-016 SHALL assert tgt_ready combinationally in IDLE and HOLD, deassert in RAMP_UP/RAMP_DOWN.
REQ-017 SHALL accept a target on a cycle with tgt_valid && tgt_ready; new target = min(tgt_duty, tgt_max).
REQ-018 SHALL on acceptance load max_value <= tgt_max next cycle, and if duty > tgt_max, load duty <= tgt_max same cycle.
REQ-019 SHALL on acceptance go to RAMP_UP if target > duty, RAMP_DOWN if target < duty, else HOLD with done_pulse asserted the next cycle.
REQ-020 SHALL run a step counter 0..step_div, cleared on acceptance; step event when counter == step_div; step_div = 0 steps every cycle.
REQ-021 SHALL change duty by exactly 1 per step event (no wrap: never exceeds max_value, never below 0).
REQ-022 SHALL on the step making duty == target move to HOLD and assert done_pulse for exactly one cycle, the cycle after duty reaches target.
REQ-023 SHALL hold busy = 1 exactly in RAMP_UP/RAMP_DOWN.
REQ-024 SHALL ignore tgt_valid while ramping (no queueing; source must hold valid).
REQ-025 SHALL keep max_value and duty constant in HOLD and IDLE absent acceptance.

Reset
REQ-026 SHALL on rst_n = 0 set state IDLE, duty 0, max_value 0, busy 0, done_pulse 0, step counter 0, discarding any ramp in progress; tgt_ready = 1 the cycle after release.

Configuration
REQ-027 SHALL with macro PWM_FADE_BREATHE_EN defined: in HOLD with breathe_en = 1, auto-retarget to 0 if duty == max_value else to max_value, entering the ramp next cycle; done_pulse still fires at each endpoint; tgt_ready stays per REQ-016. Without macro: breathe_en ignored, no auto-retarget logic synthesized.

Structure
REQ-028 SHALL place the state enumeration and step-size constant (1) in shared package pwm_fade_pkg.
REQ-029 SHALL implement the step counter as sub-module fade_tick_gen (inputs clk, rst_n, clear, div; output tick).

Verification (BIT_WIDTH=8)
REQ-030 Reset then tgt_duty=10, tgt_max=255, step_div=0 -> duty 1..10 on consecutive cycles, busy 10 cycles, one done_pulse, tgt_ready back high.
REQ-031 From duty=10, target 4, step_div=3 -> duty decrements every 4 cycles, reaches 4 after 24 cycles, one done_pulse.
REQ-032 From duty=200, tgt_duty=250, tgt_max=100 -> max_value=100 and duty=100 next cycle, HOLD, done_pulse, busy never asserted.
REQ-033 During ramp toward 50, pulse tgt_valid with 5 -> ignored, ramp completes at 50; rst_n low mid-ramp -> duty=0, IDLE, done_pulse never asserted.
REQ-034 With PWM_FADE_BREATHE_EN, tgt_max=3, target 3, breathe_en=1, step_div=0 -> duty 0,1,2,3,2,1,0,1... with done_pulse at each 3 and 0.
